// File: rtl/vec_mem_seq.sv
`default_nettype none
// ============================================================================
// Module      : vec_mem_seq
// Description : Memory-side sequencer for VLD/VST. Moves one vector of LANES
//               DATA_W-bit lanes between the register file and a DATA_W-wide
//               data memory, one lane per mem_ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module vec_mem_seq #(
  parameter int LANES  = 16,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    is_store,
  input  logic [ADDR_W-1:0]       base_addr,
  input  logic [LANES*DATA_W-1:0] wdata,
  output logic [LANES*DATA_W-1:0] rdata,
  output logic                    busy,
  output logic                    done,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic                    mem_re,
  output logic                    mem_we,
  output logic [DATA_W-1:0]       mem_wdata,
  input  logic [DATA_W-1:0]       mem_rdata,
  input  logic                    mem_ready
);

  localparam int                VEC_W       = LANES * DATA_W;
  localparam int                LANE_W      = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LANE_W-1:0] C_LAST_LANE = LANE_W'(LANES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_STORE  = 2'd2,
    S_FINISH = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [LANE_W-1:0] lane_q, lane_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [VEC_W-1:0]  wdata_q, wdata_d;
  // Loaded lanes collect here so rdata only ever changes as a whole vector.
  logic [VEC_W-1:0]  shadow_q, shadow_d;
  logic [VEC_W-1:0]  rdata_q, rdata_d;

  logic [ADDR_W-1:0] w_lane_addr;
  logic [DATA_W-1:0] w_lane_wdata;

  // Address wraps naturally modulo 2^ADDR_W.
  assign w_lane_addr  = base_q + ADDR_W'(lane_q);
  assign w_lane_wdata = wdata_q[int'(lane_q)*DATA_W +: DATA_W];
  assign rdata        = rdata_q;

  // Next-state and output decode; outputs are pure functions of state so an
  // asynchronous reset forces them to zero immediately.
  always_comb begin
    state_d   = state_q;
    lane_d    = lane_q;
    base_d    = base_q;
    wdata_d   = wdata_q;
    shadow_d  = shadow_q;
    rdata_d   = rdata_q;
    busy      = 1'b0;
    done      = 1'b0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d  = base_addr;
          wdata_d = wdata;
          lane_d  = '0;
          state_d = is_store ? S_STORE : S_LOAD;
        end
      end

      S_LOAD: begin
        busy     = 1'b1;
        mem_re   = 1'b1;
        mem_addr = w_lane_addr;
        if (mem_ready) begin
          shadow_d[int'(lane_q)*DATA_W +: DATA_W] = mem_rdata;
          lane_d = lane_q + LANE_W'(1);
          if (lane_q == C_LAST_LANE) begin
            rdata_d = shadow_d;
            state_d = S_FINISH;
          end
        end
      end

      S_STORE: begin
        busy      = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = w_lane_addr;
        mem_wdata = w_lane_wdata;
        if (mem_ready) begin
          lane_d = lane_q + LANE_W'(1);
          if (lane_q == C_LAST_LANE) begin
            state_d = S_FINISH;
          end
        end
      end

      S_FINISH: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      lane_q   <= '0;
      base_q   <= '0;
      wdata_q  <= '0;
      shadow_q <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      lane_q   <= lane_d;
      base_q   <= base_d;
      wdata_q  <= wdata_d;
      shadow_q <= shadow_d;
      rdata_q  <= rdata_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vec_mem_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_vec_mem_seq
// Description : Directed self-checking bench for vec_mem_seq with a memory
//               model, an access-sequence scoreboard and literal spot checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vec_mem_seq;

  logic         clk       = 1'b0;
  logic         rst_n     = 1'b0;
  logic         start     = 1'b0;
  logic         is_store  = 1'b0;
  logic [15:0]  base_addr = '0;
  logic [255:0] wdata     = '0;
  logic [255:0] rdata;
  logic         busy;
  logic         done;
  logic [15:0]  mem_addr;
  logic         mem_re;
  logic         mem_we;
  logic [15:0]  mem_wdata;
  logic [15:0]  mem_rdata;
  logic         mem_ready = 1'b1;

  logic [15:0]  mem     [0:65535];
  logic [15:0]  ref_mem [0:65535];

  typedef struct {
    logic [15:0] addr;
    logic        we;
    logic [15:0] data;
  } acc_t;

  acc_t         exp_q[$];
  int           vectors       = 0;
  int           errors        = 0;
  int           done_cnt      = 0;
  bit           armed         = 1'b0;
  bit           exp_is_load   = 1'b0;
  logic [255:0] exp_load_vec  = '0;
  logic [255:0] exp_rdata_cur = '0;
  logic [15:0]  stall_addr    = 16'h0000;
  int           stall_left    = 0;

  vec_mem_seq #(
    .LANES  (16),
    .DATA_W (16),
    .ADDR_W (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .is_store  (is_store),
    .base_addr (base_addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .busy      (busy),
    .done      (done),
    .mem_addr  (mem_addr),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Memory model: combinational read, write on a handshaking edge.
  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (rst_n && mem_we && mem_ready) mem[mem_addr] = mem_wdata;
  end

  // Ready generator: stalls the access at stall_addr for stall_left cycles.
  always @(posedge clk) begin
    #1;
    if (rst_n && (mem_re || mem_we) && mem_addr == stall_addr && stall_left > 0) begin
      mem_ready  = 1'b0;
      stall_left = stall_left - 1;
    end else begin
      mem_ready = 1'b1;
    end
  end

  // Per-cycle compare against the expected access sequence and result.
  always @(negedge clk) begin
    acc_t h;
    if (!rst_n) begin
      chk("rst_busy",      256'(busy),      '0);
      chk("rst_done",      256'(done),      '0);
      chk("rst_re_we",     256'(mem_re | mem_we), '0);
      chk("rst_mem_addr",  256'(mem_addr),  '0);
      chk("rst_mem_wdata", 256'(mem_wdata), '0);
      chk("rst_rdata",     rdata,           '0);
    end else begin
      if (done) done_cnt++;
      chk("re_we_exclusive", 256'(mem_re & mem_we), '0);
      if (armed && exp_q.size() > 0) begin
        h = exp_q[0];
        chk("access_active", 256'(mem_re | mem_we), 256'(1));
        chk("busy_active",   256'(busy),            256'(1));
        chk("done_early",    256'(done),            '0);
        chk("mem_addr",      256'(mem_addr),        256'(h.addr));
        chk("mem_dir_we",    256'(mem_we),          256'(h.we));
        if (h.we) chk("mem_wdata", 256'(mem_wdata), 256'(h.data));
        if (mem_ready && (mem_re || mem_we)) void'(exp_q.pop_front());
      end else if (armed) begin
        chk("done_pulse",    256'(done),            256'(1));
        chk("busy_finish",   256'(busy),            256'(1));
        chk("finish_no_acc", 256'(mem_re | mem_we), '0);
        if (exp_is_load) exp_rdata_cur = exp_load_vec;
        armed = 1'b0;
      end else begin
        chk("idle_busy", 256'(busy),            '0);
        chk("idle_done", 256'(done),            '0);
        chk("idle_acc",  256'(mem_re | mem_we), '0);
      end
      chk("rdata", rdata, exp_rdata_cur);
    end
  end

  // Presents one request and builds the expected traffic and result.
  task automatic issue(input bit st, input logic [15:0] base, input logic [255:0] wd);
    logic [15:0] a;
    acc_t        e;
    @(posedge clk); #1;
    start     = 1'b1;
    is_store  = st;
    base_addr = base;
    wdata     = wd;
    exp_q.delete();
    for (int i = 0; i < 16; i++) begin
      a      = base + 16'(i);
      e.addr = a;
      e.we   = st;
      e.data = st ? wd[i*16 +: 16] : 16'h0000;
      exp_q.push_back(e);
      if (st) ref_mem[a] = wd[i*16 +: 16];
      else    exp_load_vec[i*16 +: 16] = ref_mem[a];
    end
    exp_is_load = !st;
    @(posedge clk); #1;
    armed     = 1'b1;
    start     = 1'b0;
    is_store  = ~st;
    base_addr = ~base;
    wdata     = ~wd;
  endtask

  // Waits for busy to drop; optionally fires start at cycle 5 and in FINISH.
  task automatic run_to_idle(input int exp_cycles, input bit poke);
    int n;
    int d0;
    bit idle;
    n    = 0;
    d0   = done_cnt;
    idle = 1'b0;
    while (!idle && n < 200) begin
      @(posedge clk); #1;
      n++;
      start = 1'b0;
      if (!busy) begin
        idle = 1'b1;
      end else if (poke && (n == 5 || done)) begin
        start     = 1'b1;
        is_store  = ~is_store;
        base_addr = 16'hBEEF;
        wdata     = {16{16'hDEAD}};
      end
    end
    chk("latency",       256'(n),              256'(exp_cycles));
    chk("done_count",    256'(done_cnt - d0),  256'(1));
    chk("queue_drained", 256'(exp_q.size()),   '0);
  endtask

  initial begin
    logic [255:0] wd;
    int           n;

    for (int i = 0; i < 65536; i++) begin
      mem[i]     = 16'(i) ^ 16'hA5A5;
      ref_mem[i] = 16'(i) ^ 16'hA5A5;
    end
    for (int i = 0; i < 16; i++) begin
      mem[16'h0100 + i]     = 16'h3C00 + 16'(i);
      ref_mem[16'h0100 + i] = 16'h3C00 + 16'(i);
    end

    // Reset state
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy",  256'(busy),              '0);
    chk("reset_done",  256'(done),              '0);
    chk("reset_acc",   256'(mem_re | mem_we),   '0);
    chk("reset_addr",  256'(mem_addr),          '0);
    chk("reset_wdata", 256'(mem_wdata),         '0);
    chk("reset_rdata", rdata,                   '0);
    #2 rst_n = 1'b1;

    // Plain load
    issue(1'b0, 16'h0100, '0);
    run_to_idle(17, 1'b0);
    chk("t1_lane0",  256'(rdata[15:0]),    256'(16'h3C00));
    chk("t1_lane15", 256'(rdata[255:240]), 256'(16'h3C0F));

    // Plain store
    for (int i = 0; i < 16; i++) wd[i*16 +: 16] = 16'h4000 | 16'(i);
    issue(1'b1, 16'h0200, wd);
    run_to_idle(17, 1'b0);
    for (int i = 0; i < 16; i++) chk("t2_mem", 256'(mem[16'h0200 + i]), 256'(ref_mem[16'h0200 + i]));
    chk("t2_mem_0205",    256'(mem[16'h0205]), 256'(16'h4005));
    chk("t2_rdata_keep",  256'(rdata[15:0]),   256'(16'h3C00));

    // Address wrap
    issue(1'b0, 16'hFFFA, '0);
    run_to_idle(17, 1'b0);
    chk("t3_lane5",  256'(rdata[95:80]),   256'(16'h5A5A));
    chk("t3_lane6",  256'(rdata[111:96]),  256'(16'hA5A5));
    chk("t3_lane15", 256'(rdata[255:240]), 256'(16'hA5AC));

    // Three wait states on lane 5 of a store
    for (int i = 0; i < 16; i++) wd[i*16 +: 16] = 16'h5000 | 16'(i);
    stall_addr = 16'h0205;
    stall_left = 3;
    issue(1'b1, 16'h0200, wd);
    run_to_idle(20, 1'b0);
    chk("t4_stalls_used", 256'(stall_left),    '0);
    chk("t4_mem_0205",    256'(mem[16'h0205]), 256'(16'h5005));
    for (int i = 0; i < 16; i++) chk("t4_mem", 256'(mem[16'h0200 + i]), 256'(ref_mem[16'h0200 + i]));

    // Start while busy is ignored
    issue(1'b0, 16'h0100, '0);
    run_to_idle(17, 1'b1);
    chk("t5_no_write", 256'(mem[16'hBEEF]),  256'(16'h1B4A));
    chk("t5_lane0",    256'(rdata[15:0]),    256'(16'h3C00));

    // Asynchronous reset during lane 8 of a load
    issue(1'b0, 16'h0100, '0);
    n = 0;
    while (mem_addr != 16'h0108 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t6_reach_lane8", 256'(mem_addr), 256'(16'h0108));
    #1;
    rst_n         = 1'b0;
    armed         = 1'b0;
    exp_q.delete();
    exp_rdata_cur = '0;
    #1;
    chk("t6_busy",  256'(busy),            '0);
    chk("t6_acc",   256'(mem_re | mem_we), '0);
    chk("t6_addr",  256'(mem_addr),        '0);
    chk("t6_rdata", rdata,                 '0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    issue(1'b0, 16'h0200, '0);
    run_to_idle(17, 1'b0);
    chk("t6_lane3", 256'(rdata[63:48]), 256'(16'h5003));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
`default_nettype wire
